pwm_multi: RTL and testbench

Parametrised multi-channel successor to the single-channel speed-selectable PWM core. It drives CHANNELS independent PWM outputs from one shared prescaler and one period counter. Each channel has its own duty value, double-buffered so updates never glitch. A mode input selects edge-aligned or center-aligned waveforms. It sits directly behind the top-level pin wrapper: duty writes and configuration come from ui_in/uio_in, and PWM drives uo_out.

---
 rtl/pwm_multi_pkg.sv | 19 +
 rtl/pwm_prescaler.sv | 34 +++
 rtl/pwm_multi.sv | 109 ++++++++++
 tb/tb_pwm_multi.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/pwm_multi_pkg.sv
// Shared types and sizing helpers for the multi-channel PWM generator.
package pwm_multi_pkg;

  typedef enum logic {
    MODE_EDGE   = 1'b0,
    MODE_CENTER = 1'b1
  } mode_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  // Prescaler must hold 2^(2^speed_bits - 1) - 1, the largest divide-by count.
  function automatic int presc_width(input int speed_bits);
    return (1 << speed_bits) - 1;
  endfunction

endpackage

// File: rtl/pwm_prescaler.sv
// Shared prescaler: emits one tick every 2^speed clocks while enabled.
module pwm_prescaler
  import pwm_multi_pkg::*;
#(
  parameter int SPEED_BITS = 3
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [SPEED_BITS-1:0] speed,
  output logic                  tick
);

  localparam int PW = presc_width(SPEED_BITS);

  logic [PW-1:0] presc_q, presc_d;
  logic [PW:0]   limit;

  // >= rather than == so lowering speed mid-count ticks at once instead of wrapping.
  always_comb begin
    limit   = ((PW + 1)'(1) << speed) - (PW + 1)'(1);
    tick    = enable && ({1'b0, presc_q} >= limit);
    presc_d = (!enable || tick) ? '0 : presc_q + PW'(1);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end

endmodule

// File: rtl/pwm_multi.sv
// Multi-channel PWM: shared prescaler and period counter, double-buffered
// per-channel duty, edge- or center-aligned compare.
module pwm_multi
  import pwm_multi_pkg::*;
#(
  parameter int CHANNELS   = 4,
  parameter int WIDTH      = 8,
  parameter int SPEED_BITS = 3,
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [SPEED_BITS-1:0] speed,
  input  logic                  center_mode,
  input  logic                  wr_en,
  input  logic [CW-1:0]         wr_ch,
  input  logic [WIDTH-1:0]      wr_duty,
  output logic [CHANNELS-1:0]   PWM,
  output logic                  period_end
);

  localparam logic [WIDTH-1:0] MAX = '1;

  logic                tick;
  logic                boundary;
  logic [WIDTH-1:0]    cnt_q, cnt_d;
  dir_e                dir_q, dir_d;
  logic [WIDTH-1:0]    duty_q   [CHANNELS];
  logic [WIDTH-1:0]    duty_d   [CHANNELS];
  logic [WIDTH-1:0]    shadow_q [CHANNELS];
  logic [WIDTH-1:0]    shadow_d [CHANNELS];
  logic [CHANNELS-1:0] pwm_q, pwm_d;
  logic                period_end_q;

  pwm_prescaler #(
    .SPEED_BITS(SPEED_BITS)
  ) u_presc (
    .clock (clock),
    .reset (reset),
    .enable(enable),
    .speed (speed),
    .tick  (tick)
  );

  // Center mode holds cnt at each endpoint for one extra tick while dir flips.
  always_comb begin
    cnt_d    = cnt_q;
    dir_d    = dir_q;
    boundary = 1'b0;
    if (!enable) begin
      cnt_d = '0;
      dir_d = DIR_UP;
    end else if (center_mode == MODE_CENTER) begin
      if (tick) begin
        if (dir_q == DIR_UP) begin
          if (cnt_q == MAX) dir_d = DIR_DOWN;
          else              cnt_d = cnt_q + WIDTH'(1);
        end else begin
          if (cnt_q == '0) begin
            dir_d    = DIR_UP;
            boundary = 1'b1;
          end else begin
            cnt_d = cnt_q - WIDTH'(1);
          end
        end
      end
    end else begin
      dir_d = DIR_UP;
      if (tick) begin
        cnt_d    = cnt_q + WIDTH'(1);
        boundary = (cnt_q == MAX);
      end
    end
  end

  always_comb begin
    pwm_d = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      duty_d[i]   = (wr_en && wr_ch == CW'(i)) ? wr_duty : duty_q[i];
      shadow_d[i] = (!enable || boundary) ? duty_q[i] : shadow_q[i];
      pwm_d[i]    = enable && (cnt_q < shadow_q[i]);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q        <= '0;
      dir_q        <= DIR_UP;
      pwm_q        <= '0;
      period_end_q <= 1'b0;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        duty_q[i]   <= '0;
        shadow_q[i] <= '0;
      end
    end else begin
      cnt_q        <= cnt_d;
      dir_q        <= dir_d;
      pwm_q        <= pwm_d;
      period_end_q <= boundary;
      duty_q       <= duty_d;
      shadow_q     <= shadow_d;
    end
  end

  assign PWM        = pwm_q;
  assign period_end = period_end_q;

endmodule

// File: tb/tb_pwm_multi.sv
// Directed bench for pwm_multi: duty windows per period, mode/speed changes, reset.
module tb_pwm_multi;

  // Five channels so wr_ch is 3 bits wide and out-of-range indices are drivable.
  localparam int CH = 5;
  localparam int W  = 8;
  localparam int SB = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          enable = 1'b0;
  logic [SB-1:0] speed = '0;
  logic          center_mode = 1'b0;
  logic          wr_en = 1'b0;
  logic [2:0]    wr_ch = '0;
  logic [W-1:0]  wr_duty = '0;
  logic [CH-1:0] PWM;
  logic          period_end;

  int checks = 0;
  int failures = 0;
  int hi_cnt [CH];
  int pe_cnt;
  int lat;
  logic [CH-1:0] first_pwm, mid_pwm, last_pwm;
  logic          last_pe;

  pwm_multi #(
    .CHANNELS  (CH),
    .WIDTH     (W),
    .SPEED_BITS(SB)
  ) dut (
    .clock      (clk),
    .reset      (rst),
    .enable     (enable),
    .speed      (speed),
    .center_mode(center_mode),
    .wr_en      (wr_en),
    .wr_ch      (wr_ch),
    .wr_duty    (wr_duty),
    .PWM        (PWM),
    .period_end (period_end)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_duty(input int ch, input int val);
    wr_en   = 1'b1;
    wr_ch   = 3'(ch);
    wr_duty = W'(val);
    step();
    wr_en   = 1'b0;
  endtask

  // Steps at least once, then until period_end is seen; n = steps taken.
  task automatic wait_pe(input string tag, input int budget, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (period_end !== 1'b1 && n < budget);
    check(tag, int'(period_end), 1);
  endtask

  task automatic measure(input int n, input int wr_at, input int wc, input int wv);
    for (int c = 0; c < CH; c++) hi_cnt[c] = 0;
    pe_cnt = 0;
    for (int i = 0; i < n; i++) begin
      if (i == wr_at) begin
        wr_en   = 1'b1;
        wr_ch   = 3'(wc);
        wr_duty = W'(wv);
      end
      step();
      wr_en = 1'b0;
      for (int c = 0; c < CH; c++) hi_cnt[c] += int'(PWM[c]);
      pe_cnt += int'(period_end);
      if (i == 0)     first_pwm = PWM;
      if (i == n / 2) mid_pwm   = PWM;
    end
    last_pwm = PWM;
    last_pe  = period_end;
  endtask

  initial begin
    step();
    step();
    check("rst_pwm", int'(PWM), 0);
    check("rst_pe", int'(period_end), 0);
    rst = 1'b0;
    step();

    // Edge mode, speed 0, ch0 = 64
    write_duty(0, 64);
    enable = 1'b1;
    wait_pe("e0_sync", 600, lat);
    measure(256, -1, 0, 0);
    check("e0_ch0_hi", hi_cnt[0], 64);
    check("e0_ch1_hi", hi_cnt[1], 0);
    check("e0_ch3_hi", hi_cnt[3], 0);
    check("e0_pe_cnt", pe_cnt, 1);
    check("e0_pe_last", int'(last_pe), 1);

    // ch1 = 0, ch2 = MAX
    write_duty(1, 0);
    write_duty(2, 255);
    wait_pe("e1_sync", 600, lat);
    measure(256, -1, 0, 0);
    check("e1_ch0_hi", hi_cnt[0], 64);
    check("e1_ch1_hi", hi_cnt[1], 0);
    check("e1_ch2_hi", hi_cnt[2], 255);
    check("e1_pe_cnt", pe_cnt, 1);

    // Speed 2, then drop to 0 mid-count
    speed = 3'd2;
    wait_pe("s2_sync", 2100, lat);
    measure(1024, -1, 0, 0);
    check("s2_ch0_hi", hi_cnt[0], 256);
    check("s2_ch2_hi", hi_cnt[2], 1020);
    check("s2_pe_cnt", pe_cnt, 1);
    check("s2_pe_last", int'(last_pe), 1);
    step();
    step();
    speed = 3'd0;
    wait_pe("sdec_sync", 2100, lat);
    check("sdec_lat", lat, 256);

    // Mid-period write, write at boundary, out-of-range writes
    measure(256, 100, 0, 32);
    check("w1_ch0_hi", hi_cnt[0], 64);
    check("w1_pe_last", int'(last_pe), 1);
    measure(256, 255, 0, 100);
    check("w2_ch0_hi", hi_cnt[0], 32);
    measure(256, -1, 0, 0);
    check("w3_ch0_hi", hi_cnt[0], 32);
    measure(256, 10, 5, 200);
    check("w4_ch0_hi", hi_cnt[0], 100);
    measure(256, 10, 7, 200);
    check("w5_ch0_hi", hi_cnt[0], 100);
    check("w5_ch1_hi", hi_cnt[1], 0);
    check("w5_ch2_hi", hi_cnt[2], 255);
    check("w5_ch3_hi", hi_cnt[3], 0);
    check("w5_ch4_hi", hi_cnt[4], 0);

    // Enable low: outputs forced low, shadows track duty
    enable = 1'b0;
    write_duty(4, 50);
    step();
    step();
    step();
    check("dis_pwm", int'(PWM), 0);
    check("dis_pe", int'(period_end), 0);
    enable = 1'b1;
    measure(256, -1, 0, 0);
    check("en_ch0_hi", hi_cnt[0], 100);
    check("en_ch2_hi", hi_cnt[2], 255);
    check("en_ch3_hi", hi_cnt[3], 0);
    check("en_ch4_hi", hi_cnt[4], 50);
    check("en_pe_cnt", pe_cnt, 1);
    check("en_pe_last", int'(last_pe), 1);

    // Center mode
    write_duty(0, 64);
    center_mode = 1'b1;
    wait_pe("c_sync", 1500, lat);
    measure(512, -1, 0, 0);
    check("c_ch0_hi", hi_cnt[0], 128);
    check("c_ch1_hi", hi_cnt[1], 0);
    check("c_ch2_hi", hi_cnt[2], 510);
    check("c_ch4_hi", hi_cnt[4], 100);
    check("c_pe_cnt", pe_cnt, 1);
    check("c_pe_last", int'(last_pe), 1);
    check("c_first_ch0", int'(first_pwm[0]), 1);
    check("c_mid_ch0", int'(mid_pwm[0]), 0);
    check("c_last_ch0", int'(last_pwm[0]), 1);

    // Async reset mid-period with PWM high
    for (int i = 0; i < 10; i++) step();
    check("pre_rst_ch0", int'(PWM[0]), 1);
    #2;
    rst = 1'b1;
    #1;
    check("arst_pwm", int'(PWM), 0);
    check("arst_pe", int'(period_end), 0);
    step();
    rst = 1'b0;
    measure(600, -1, 0, 0);
    check("post_rst_hi", hi_cnt[0] + hi_cnt[1] + hi_cnt[2] + hi_cnt[3] + hi_cnt[4], 0);
    check("post_rst_pe", pe_cnt, 1);
    write_duty(3, 10);
    wait_pe("post_rst_sync", 1500, lat);
    measure(512, -1, 0, 0);
    check("post_rst_ch3_hi", hi_cnt[3], 20);
    check("post_rst_ch0_hi", hi_cnt[0], 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
